// File: rtl/vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_monitor
// Description : Passive VGA stream checker that measures per-frame geometry,
//               checksums and per-sprite pixel counts, and reports lock.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_monitor #(
    parameter int H_EXPECT  = 800,
    parameter int V_EXPECT  = 525,
    parameter int HA_EXPECT = 640,
    parameter int VA_EXPECT = 480,
    parameter int CNT_W     = 20,
    parameter int TIMEOUT   = 840000
) (
    input  logic             VGA_CLK,
    input  logic             RESET,
    input  logic             VGA_HS,
    input  logic             VGA_VS,
    input  logic             VGA_BLANK_N,
    input  logic [7:0]       VGA_R,
    input  logic [7:0]       VGA_G,
    input  logic [7:0]       VGA_B,
    input  logic [7:0]       SPRITES_EN,
    input  logic [2:0]       SEL,
    output logic [11:0]      H_TOTAL,
    output logic [10:0]      V_TOTAL,
    output logic [11:0]      H_ACTIVE,
    output logic [10:0]      V_ACTIVE,
    output logic [23:0]      CHECKSUM,
    output logic [CNT_W-1:0] SPRITE_PIXELS,
    output logic             FRAME_DONE,
    output logic             LOCKED,
    output logic             TIMING_ERR
);

    localparam int              c_FW       = $clog2(TIMEOUT + 1);
    localparam logic [c_FW-1:0] c_TMO      = c_FW'(TIMEOUT);
    localparam logic [11:0]     c_H_EXP    = 12'(H_EXPECT);
    localparam logic [10:0]     c_V_EXP    = 11'(V_EXPECT);
    localparam logic [11:0]     c_HA_EXP   = 12'(HA_EXPECT);
    localparam logic [10:0]     c_VA_EXP   = 11'(VA_EXPECT);
    localparam logic [CNT_W-1:0] c_SPR_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] c_ST_SEARCH  = 2'd0;
    localparam logic [1:0] c_ST_MEASURE = 2'd1;
    localparam logic [1:0] c_ST_LOCKED  = 2'd2;

    // input capture (s1) and previous-sync stage (s2)
    logic       r_hs1, r_vs1, r_blank1, r_hs2, r_vs2;
    logic [7:0] r_r1, r_g1, r_b1, r_spr1;

    logic [11:0] r_hcnt, r_hper, r_lact, r_hact;
    logic [10:0] r_vcnt, r_vact;
    logic        r_line_bad;
    logic [23:0] r_csum;
    logic [CNT_W-1:0] r_spr [8];
    logic [c_FW-1:0]  r_fcnt;

    logic [1:0]  r_state;
    logic        r_done1, r_err1;
    logic [11:0] r_snap_htot, r_snap_hact;
    logic [10:0] r_snap_vtot, r_snap_vact;
    logic [23:0] r_snap_csum;
    logic [CNT_W-1:0] r_snap_spr [8];

    logic        w_line_start, w_frame_start, w_lact_hit, w_latch, w_match, w_bad_f;
    logic [9:0]  w_pix;
    logic [7:0]  w_hit;
    logic [11:0] w_htot_f, w_hact_f;
    logic [10:0] w_vtot_f, w_vact_f, w_vcnt_inc, w_vact_inc;

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            r_hs1 <= 1'b0; r_vs1 <= 1'b0; r_blank1 <= 1'b0;
            r_hs2 <= 1'b0; r_vs2 <= 1'b0;
            r_r1 <= '0; r_g1 <= '0; r_b1 <= '0; r_spr1 <= '0;
        end else begin
            r_hs1 <= VGA_HS; r_vs1 <= VGA_VS; r_blank1 <= VGA_BLANK_N;
            r_hs2 <= r_hs1;  r_vs2 <= r_vs1;
            r_r1 <= VGA_R; r_g1 <= VGA_G; r_b1 <= VGA_B; r_spr1 <= SPRITES_EN;
        end
    end

    assign w_line_start  = r_hs2 & ~r_hs1;
    assign w_frame_start = r_vs2 & ~r_vs1;
    assign w_pix         = 10'(r_r1) + 10'(r_g1) + 10'(r_b1);
    assign w_hit         = {8{r_blank1}} & r_spr1;
    assign w_vcnt_inc    = (r_vcnt == 11'h7FF) ? r_vcnt : r_vcnt + 11'd1;
    assign w_vact_inc    = (r_vact == 11'h7FF) ? r_vact : r_vact + 11'd1;
    assign w_lact_hit    = w_line_start && (r_lact != 12'd0);

    // A line start coinciding with the frame start closes the ending frame
    assign w_vtot_f = w_line_start ? w_vcnt_inc : r_vcnt;
    assign w_vact_f = w_lact_hit ? w_vact_inc : r_vact;
    assign w_hact_f = w_lact_hit ? r_lact : r_hact;
    assign w_htot_f = w_line_start ? r_hcnt : r_hper;
    assign w_bad_f  = r_line_bad | (w_line_start && (r_hcnt != c_H_EXP));
    assign w_match  = (w_vtot_f == c_V_EXP) && (w_hact_f == c_HA_EXP) &&
                      (w_vact_f == c_VA_EXP) && !w_bad_f;
    assign w_latch  = w_frame_start && (r_state != c_ST_SEARCH);

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            r_hcnt <= '0; r_hper <= '0; r_lact <= '0; r_hact <= '0;
            r_vcnt <= '0; r_vact <= '0; r_line_bad <= 1'b0; r_csum <= '0;
        end else begin
            if (w_line_start) begin
                r_hcnt <= 12'd1;
                r_hper <= r_hcnt;
                r_lact <= {11'd0, r_blank1};
            end else begin
                if (r_hcnt != 12'hFFF) r_hcnt <= r_hcnt + 12'd1;
                if (r_blank1 && r_lact != 12'hFFF) r_lact <= r_lact + 12'd1;
            end

            if (w_frame_start) begin
                r_vcnt     <= '0;
                r_vact     <= '0;
                r_hact     <= '0;
                r_line_bad <= 1'b0;
                r_csum     <= r_blank1 ? 24'(w_pix) : 24'd0;
            end else begin
                if (w_line_start) begin
                    r_vcnt <= w_vcnt_inc;
                    if (r_hcnt != c_H_EXP) r_line_bad <= 1'b1;
                end
                if (w_lact_hit) begin
                    r_vact <= w_vact_inc;
                    r_hact <= r_lact;
                end
                if (r_blank1) r_csum <= r_csum + 24'(w_pix);
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                r_spr[i]      <= '0;
                r_snap_spr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_frame_start)
                    r_spr[i] <= CNT_W'(w_hit[i]);
                else if (w_hit[i] && r_spr[i] != c_SPR_MAX)
                    r_spr[i] <= r_spr[i] + CNT_W'(1);
                if (w_latch) r_snap_spr[i] <= r_spr[i];
            end
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            r_state     <= c_ST_SEARCH;
            r_fcnt      <= '0;
            r_done1     <= 1'b0;
            r_err1      <= 1'b0;
            r_snap_htot <= '0; r_snap_vtot <= '0;
            r_snap_hact <= '0; r_snap_vact <= '0;
            r_snap_csum <= '0;
        end else begin
            r_done1 <= 1'b0;
            r_err1  <= 1'b0;
            if (w_frame_start)         r_fcnt <= '0;
            else if (r_fcnt != c_TMO)  r_fcnt <= r_fcnt + c_FW'(1);

            if (w_frame_start) begin
                if (r_state == c_ST_SEARCH) begin
                    r_state <= c_ST_MEASURE;
                end else begin
                    r_snap_htot <= w_htot_f;
                    r_snap_vtot <= w_vtot_f;
                    r_snap_hact <= w_hact_f;
                    r_snap_vact <= w_vact_f;
                    r_snap_csum <= r_csum;
                    r_done1     <= 1'b1;
                    r_err1      <= !w_match;
                    r_state     <= w_match ? c_ST_LOCKED : c_ST_MEASURE;
                end
            end else if (r_fcnt == c_TMO) begin
                r_state <= c_ST_SEARCH;
            end
        end
    end

    // Publish stage: results, strobes and lock change together
    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            H_TOTAL <= '0; V_TOTAL <= '0; H_ACTIVE <= '0; V_ACTIVE <= '0;
            CHECKSUM <= '0; SPRITE_PIXELS <= '0;
            FRAME_DONE <= 1'b0; TIMING_ERR <= 1'b0; LOCKED <= 1'b0;
        end else begin
            H_TOTAL       <= r_snap_htot;
            V_TOTAL       <= r_snap_vtot;
            H_ACTIVE      <= r_snap_hact;
            V_ACTIVE      <= r_snap_vact;
            CHECKSUM      <= r_snap_csum;
            SPRITE_PIXELS <= r_snap_spr[SEL];
            FRAME_DONE    <= r_done1;
            TIMING_ERR    <= r_err1;
            LOCKED        <= (r_state == c_ST_LOCKED);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_monitor
// Description : Randomized stream bench for vga_frame_monitor with a
//               frame-level scoreboard built from the driven pixels.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_frame_monitor;

    localparam int H = 40, V = 30, HA = 32, VA = 24, HB = 6, VB = 3;
    localparam int CW = 9, TMO = 3000, SMAX = (1 << CW) - 1;

    logic VGA_CLK = 1'b0, RESET, VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0] VGA_R, VGA_G, VGA_B, SPRITES_EN;
    logic [2:0] SEL;
    logic [11:0] H_TOTAL, H_ACTIVE;
    logic [10:0] V_TOTAL, V_ACTIVE;
    logic [23:0] CHECKSUM;
    logic [CW-1:0] SPRITE_PIXELS;
    logic FRAME_DONE, LOCKED, TIMING_ERR;

    vga_frame_monitor #(
        .H_EXPECT(H), .V_EXPECT(V), .HA_EXPECT(HA), .VA_EXPECT(VA),
        .CNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .SPRITES_EN(SPRITES_EN), .SEL(SEL), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .CHECKSUM(CHECKSUM),
        .SPRITE_PIXELS(SPRITE_PIXELS), .FRAME_DONE(FRAME_DONE), .LOCKED(LOCKED),
        .TIMING_ERR(TIMING_ERR)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int errors = 0, checks = 0, cyc = 0;
    logic [2:0] sel_q = 3'd0;
    bit rst_q = 1'b0;
    always @(posedge VGA_CLK) begin
        cyc   <= cyc + 1;
        sel_q <= SEL;
        rst_q <= RESET;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame being driven
    int f_lines, f_vact, f_hact, f_last; bit f_bad; logic [23:0] f_csum; int f_spr[8];
    // Frame awaiting its report
    bit pend = 1'b0, armed = 1'b0; int pend_cyc;
    int e_htot, e_vtot, e_hact, e_vact; logic [23:0] e_csum; int e_spr[8]; bit e_match;
    // Last reported results
    int rep_htot, rep_vtot, rep_hact, rep_vact; logic [23:0] rep_csum; int rep_spr[8];

    task automatic frame_boundary();
        if (armed) begin
            e_htot = f_last; e_vtot = f_lines; e_hact = f_hact; e_vact = f_vact;
            e_csum = f_csum;
            for (int i = 0; i < 8; i++) e_spr[i] = f_spr[i];
            e_match = (f_lines == V) && (f_hact == HA) && (f_vact == VA) && !f_bad;
            pend = 1'b1;
            pend_cyc = cyc + 3;
        end
        armed = 1'b1;
        f_lines = 0; f_vact = 0; f_hact = 0; f_last = 0; f_bad = 1'b0; f_csum = '0;
        for (int i = 0; i < 8; i++) f_spr[i] = 0;
    endtask

    task automatic drive_frame(input int nlines, input int bad_line, input int bad_len,
                               input int ha, input int rst_line, input bit vs_on);
        int len, lact;
        bit act;
        logic [7:0] s;
        for (int l = 0; l < nlines; l++) begin
            len  = (l == bad_line) ? bad_len : H;
            lact = 0;
            for (int c = 0; c < len; c++) begin
                @(negedge VGA_CLK);
                if (vs_on && l == 0 && c == 0) frame_boundary();
                RESET = (l == rst_line && c == 0);
                if (RESET) begin armed = 1'b0; pend = 1'b0; end
                VGA_HS = (c >= 4);
                VGA_VS = !(vs_on && l < 2);
                act = (l >= VB && l < VB + VA && c >= HB && c < HB + ha);
                VGA_BLANK_N = act;
                VGA_R = 8'($urandom); VGA_G = 8'($urandom); VGA_B = 8'($urandom);
                s = 8'($urandom);
                s[0] = (l >= 8 && l < 13 && c >= 10 && c < 20);
                s[7] = 1'b1;
                SPRITES_EN = s;
                if (cyc % 8 == 0) SEL = 3'($urandom_range(0, 7));
                if (act) begin
                    lact++;
                    f_csum = f_csum + VGA_R + VGA_G + VGA_B;
                    for (int i = 0; i < 8; i++)
                        if (s[i] && f_spr[i] < SMAX) f_spr[i]++;
                end
            end
            f_lines++;
            f_last = len;
            if (len != H) f_bad = 1'b1;
            if (lact > 0) begin f_vact++; f_hact = lact; end
        end
    endtask

    // Cycle monitor: strobes every cycle, results on each expected report
    bit exp_done;
    initial forever begin
        @(negedge VGA_CLK);
        if (rst_q) begin
            rep_htot = 0; rep_vtot = 0; rep_hact = 0; rep_vact = 0; rep_csum = '0;
            for (int i = 0; i < 8; i++) rep_spr[i] = 0;
            check_val("rst_h_total", H_TOTAL, 0);
            check_val("rst_v_total", V_TOTAL, 0);
            check_val("rst_h_active", H_ACTIVE, 0);
            check_val("rst_v_active", V_ACTIVE, 0);
            check_val("rst_checksum", CHECKSUM, 0);
            check_val("rst_locked", LOCKED, 0);
        end
        exp_done = pend && (cyc == pend_cyc);
        check_val("frame_done", FRAME_DONE, exp_done);
        check_val("timing_err", TIMING_ERR, exp_done && !e_match);
        if (exp_done) begin
            check_val("h_total", H_TOTAL, e_htot);
            check_val("v_total", V_TOTAL, e_vtot);
            check_val("h_active", H_ACTIVE, e_hact);
            check_val("v_active", V_ACTIVE, e_vact);
            check_val("checksum", CHECKSUM, e_csum);
            check_val("locked", LOCKED, e_match);
            rep_htot = e_htot; rep_vtot = e_vtot; rep_hact = e_hact; rep_vact = e_vact;
            rep_csum = e_csum;
            for (int i = 0; i < 8; i++) rep_spr[i] = e_spr[i];
            pend = 1'b0;
        end else if (pend && cyc > pend_cyc) begin
            pend = 1'b0;
        end
        check_val("sprite_pixels", SPRITE_PIXELS, rep_spr[sel_q]);
    end

    initial begin
        RESET = 1'b1; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_N = 1'b0;
        VGA_R = '0; VGA_G = '0; VGA_B = '0; SPRITES_EN = '0; SEL = '0;
        repeat (3) @(negedge VGA_CLK);
        RESET = 1'b0;
        repeat (4) @(negedge VGA_CLK);

        repeat (4) drive_frame(V, -1, H, HA, -1, 1'b1);
        drive_frame(V, $urandom_range(5, 25), H + 1, HA, -1, 1'b1);  // long line
        drive_frame(V, -1, H, HA, -1, 1'b1);
        drive_frame(V - 1, -1, H, HA, -1, 1'b1);                     // short frame
        drive_frame(V, -1, H, HA - 1, -1, 1'b1);                     // narrow active
        drive_frame(V, -1, H, HA, -1, 1'b1);

        // Sync loss: lines keep coming but VS never falls
        drive_frame(TMO / H + 5, -1, H, 0, -1, 1'b0);
        armed = 1'b0;
        @(negedge VGA_CLK);
        check_val("timeout_locked", LOCKED, 0);
        check_val("timeout_hold_vtot", V_TOTAL, rep_vtot);
        check_val("timeout_hold_hact", H_ACTIVE, rep_hact);
        check_val("timeout_hold_csum", CHECKSUM, rep_csum);

        repeat (3) drive_frame(V, -1, H, HA, -1, 1'b1);
        drive_frame(V, -1, H, HA, 20, 1'b1);                         // reset mid-frame
        repeat (3) drive_frame(V, -1, H, HA, -1, 1'b1);
        drive_frame(3, -1, H, HA, -1, 1'b1);                         // closes last frame
        repeat (5) @(negedge VGA_CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Passive sink for the VGA stream driven by `VGA_controller`. It samples sync, blank, colour and sprite-enable outputs on `VGA_CLK`, measures per-frame geometry, and counts active pixels per `SPRITES_EN` bit. It checks the frame against nominal timing and reports lock status. It is used on-chip as a debug/self-check block, and in simulation as the checking end of the controller benches.

## Interface

- `H_EXPECT`, 800: expected `VGA_CLK` cycles per line.
- `V_EXPECT`, 525: expected lines per frame.
- `HA_EXPECT`, 640: expected active pixels per line.
- `VA_EXPECT`, 480: expected active lines per frame.
- `CNT_W`, 20: width of per-sprite pixel counters.
- `TIMEOUT`, 840000: cycles without a frame start before lock is dropped.
- `VGA_CLK  in  1`: pixel clock. All logic is on the rising edge.
- `RESET  in  1`: synchronous, active-high reset.
- `VGA_HS  in  1`: horizontal sync, active low.
- `VGA_VS  in  1`: vertical sync, active low.
- `VGA_BLANK_N  in  1`: high during active video.
- `VGA_R`, `VGA_G`, `VGA_B`  in  8 each: pixel colour. Summed into the checksum.
- `SPRITES_EN  in  8`: per-sprite pixel enables.
- `SEL  in  3`: sprite index for readback.
- `H_TOTAL  out  12`: last measured line period, in cycles.
- `V_TOTAL  out  11`: lines in the last frame.
- `H_ACTIVE  out  12`: `VGA_BLANK_N`-high cycles on the last active line.
- `V_ACTIVE  out  11`: lines in the last frame with at least one active cycle.
- `CHECKSUM  out  24`: sum mod 2^24 of R+G+B over active pixels of the last frame.
- `SPRITE_PIXELS  out  CNT_W`: last-frame active-pixel count for sprite `SEL`.
- `FRAME_DONE  out  1`: one-cycle strobe when results update.
- `LOCKED  out  1`: the last frame matched all expected values.
- `TIMING_ERR  out  1`: one-cycle strobe, coincident with `FRAME_DONE`, on a mismatching frame.

## Operation

**Input capture and edge detection**
- All inputs pass through one register stage (s1). A second stage (s2) holds the previous HS/VS.
- Line start: s2.HS=1 and s1.HS=0.
- Frame start: s2.VS=1 and s1.VS=0.

**Counters**
- `hcnt` clears to 1 on a line start and otherwise increments, saturating at 4095. The line period is the `hcnt` value at the next line start.
- `line_bad` sets if any period within the frame is not `H_EXPECT`.
- Per-line active counter: counts s1.BLANK_N. At line start, if it is nonzero, it is latched as the last-active-line value and the active-line count increments.
- Sprite counters: `spr[i]` increments when s1.BLANK_N and s1.SPRITES_EN[i] are both high. Saturates at 2^CNT_W−1.
- Checksum: accumulates R+G+B when s1.BLANK_N is high.

**State machine**
- SEARCH (reset state): on frame start, clear accumulators → MEASURE. No `FRAME_DONE`.
- MEASURE / LOCKED, on frame start:
  - Latch all results and pulse `FRAME_DONE`.
  - Compare: `V_TOTAL`=V_EXPECT, `H_ACTIVE`=HA_EXPECT, `V_ACTIVE`=VA_EXPECT, and `line_bad` clear.
  - Match → LOCKED. Mismatch → MEASURE and pulse `TIMING_ERR`.
- Accumulators clear in the same cycle as the latch. Counting of the new frame includes the frame-start cycle's sample.
- Any state: frame-cycle counter reaching `TIMEOUT` → SEARCH. Results are held.
- `LOCKED` output is 1 only in LOCKED state.

**Boundary conditions**
- Line start and frame start in the same cycle: the line is counted in the ending frame. The new frame's line count starts at 0.
- `SEL` change mid-frame only affects readback, never the counts.

## Timing

- Reset value of every output: 0.
- Reset mid-frame returns to SEARCH. The next full frame is the first one reported.
- `FRAME_DONE`, `TIMING_ERR`, `LOCKED` and the results update together.
  - They update on the 2nd rising edge after the first edge that samples `VGA_VS` low.
  - Results are stable until the next `FRAME_DONE`.
- `SPRITE_PIXELS` is registered: `SEL` → data latency is 1 cycle.
- Nominal frame is 420000 cycles. `FRAME_DONE` period is 420000 cycles.

## Test plan

- **Nominal stream:** drive 800×525 with 640×480 active and constant RGB=FF0000.
  - → First `FRAME_DONE` after the 2nd VS fall. `LOCKED`=1.
  - → H_TOTAL=800, V_TOTAL=525, H_ACTIVE=640, V_ACTIVE=480.
  - → CHECKSUM=(255·307200) mod 2^24.
- **Sprite counts:** SPRITES_EN[0] over a 100×50 active box; bit 7 always high.
  - → SEL=0 reads 5000 one cycle after select. SEL=7 reads 307200. Others read 0.
- **Line-length fault:** one line of 801 cycles in frame 3.
  - → That frame's `FRAME_DONE` has `TIMING_ERR`=1 and `LOCKED`=0.
  - → The next clean frame restores `LOCKED`=1.
- **Sync loss:** hold `VGA_VS` high for 840000 cycles.
  - → SEARCH. `LOCKED`=0. No `FRAME_DONE`. Results are held.
- **Reset mid-frame:** assert `RESET` for 1 cycle at line 200.
  - → All outputs are 0.
  - → The first `FRAME_DONE` comes after two further VS falls.
- **Saturation:** CNT_W=8 with a 640×480 sprite → SPRITE_PIXELS=255.
